cv32e40x_xif_result_arbiter: RTL and testbench

- Parametrised successor to the single-coprocessor eXtension result channel. Merges the result channels of X_NUM_COPROC coprocessors into the core's single result port.
- Round-robin arbitration between channels.
- Tracks every outstanding offloaded ID: owner and kill status, per issue and commit events.
- Silently absorbs results of killed instructions. Flags protocol violations.
- Sits between the coprocessor result modports and the core writeback stage.
- The output is a one-entry registered stage, so there is no combinational path from coprocessor valid to core.

---
 rtl/cv32e40x_xif_result_arbiter_if.sv | 53 +++++
 rtl/cv32e40x_xif_result_arbiter.sv | 140 ++++++++++++++
 tb/tb_cv32e40x_xif_result_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cv32e40x_xif_result_arbiter_if.sv
// Grouped issue/commit/result signals between the coprocessor result channels,
// the core writeback stage, and the result arbiter.
interface cv32e40x_xif_result_arbiter_if #(
  parameter int X_NUM_COPROC = 2,
  parameter int X_ID_WIDTH   = 4,
  parameter int X_RFW_WIDTH  = 32
);
  localparam int CW  = (X_NUM_COPROC > 1) ? $clog2(X_NUM_COPROC) : 1;
  localparam int WEW = X_RFW_WIDTH / 32;

  logic                                issue_alloc_i;
  logic [X_ID_WIDTH-1:0]               issue_id_i;
  logic [CW-1:0]                       issue_coproc_i;
  logic                                commit_valid_i;
  logic [X_ID_WIDTH-1:0]               commit_id_i;
  logic                                commit_kill_i;
  logic [X_NUM_COPROC-1:0]             co_result_valid_i;
  logic [X_NUM_COPROC-1:0]             co_result_ready_o;
  logic [X_NUM_COPROC*X_ID_WIDTH-1:0]  co_result_id_i;
  logic [X_NUM_COPROC*X_RFW_WIDTH-1:0] co_result_data_i;
  logic [X_NUM_COPROC*5-1:0]           co_result_rd_i;
  logic [X_NUM_COPROC*WEW-1:0]         co_result_we_i;
  logic [X_NUM_COPROC-1:0]             co_result_exc_i;
  logic [X_NUM_COPROC*6-1:0]           co_result_exccode_i;
  logic                                result_valid_o;
  logic                                result_ready_i;
  logic [X_ID_WIDTH-1:0]               result_id_o;
  logic [X_RFW_WIDTH-1:0]              result_data_o;
  logic [4:0]                          result_rd_o;
  logic [WEW-1:0]                      result_we_o;
  logic                                result_exc_o;
  logic [5:0]                          result_exccode_o;
  logic [X_ID_WIDTH:0]                 outstanding_cnt_o;
  logic                                protocol_err_o;

  modport slave (
    input  issue_alloc_i, issue_id_i, issue_coproc_i,
    input  commit_valid_i, commit_id_i, commit_kill_i,
    input  co_result_valid_i, co_result_id_i, co_result_data_i, co_result_rd_i,
    input  co_result_we_i, co_result_exc_i, co_result_exccode_i, result_ready_i,
    output co_result_ready_o, result_valid_o, result_id_o, result_data_o, result_rd_o,
    output result_we_o, result_exc_o, result_exccode_o, outstanding_cnt_o, protocol_err_o
  );

  modport master (
    output issue_alloc_i, issue_id_i, issue_coproc_i,
    output commit_valid_i, commit_id_i, commit_kill_i,
    output co_result_valid_i, co_result_id_i, co_result_data_i, co_result_rd_i,
    output co_result_we_i, co_result_exc_i, co_result_exccode_i, result_ready_i,
    input  co_result_ready_o, result_valid_o, result_id_o, result_data_o, result_rd_o,
    input  result_we_o, result_exc_o, result_exccode_o, outstanding_cnt_o, protocol_err_o
  );
endinterface

// File: rtl/cv32e40x_xif_result_arbiter.sv
// Round-robin merge of coprocessor result channels into one registered result
// stage, with per-ID ownership/kill tracking and protocol-violation flagging.
module cv32e40x_xif_result_arbiter #(
  parameter int X_NUM_COPROC = 2,
  parameter int X_ID_WIDTH   = 4,
  parameter int X_RFW_WIDTH  = 32
) (
  input logic clk,
  input logic rst_n,
  cv32e40x_xif_result_arbiter_if.slave xif
);
  localparam int NC    = X_NUM_COPROC;
  localparam int IW    = X_ID_WIDTH;
  localparam int W     = X_RFW_WIDTH;
  localparam int CW    = (NC > 1) ? $clog2(NC) : 1;
  localparam int WEW   = W / 32;
  localparam int DEPTH = 2 ** IW;

  typedef struct packed {
    logic [IW-1:0]  id;
    logic [W-1:0]   data;
    logic [4:0]     rd;
    logic [WEW-1:0] we;
    logic           exc;
    logic [5:0]     exccode;
  } res_t;

  logic [DEPTH-1:0]         trk_valid, trk_killed;
  logic [DEPTH-1:0][CW-1:0] trk_owner;
  logic [CW-1:0]            ptr;
  logic                     out_valid;
  res_t                     out_q;
  logic                     err_q;
  logic [IW:0]              cnt_q;

  res_t [NC-1:0]    ch;
  logic [NC-1:0]    live, dead, bad, rdy;
  logic             can_load, gnt_vld, dup;
  logic [CW-1:0]    gnt, idx;
  logic [DEPTH-1:0] free;
  int               n_free, cnt_nxt;

  for (genvar c = 0; c < NC; c++) begin : g_ch
    logic hit;
    assign ch[c] = {xif.co_result_id_i[c*IW +: IW], xif.co_result_data_i[c*W +: W],
                    xif.co_result_rd_i[c*5 +: 5], xif.co_result_we_i[c*WEW +: WEW],
                    xif.co_result_exc_i[c], xif.co_result_exccode_i[c*6 +: 6]};
    assign hit     = trk_valid[ch[c].id] && (trk_owner[ch[c].id] == CW'(c));
    assign live[c] = xif.co_result_valid_i[c] &  hit & !trk_killed[ch[c].id];
    assign dead[c] = xif.co_result_valid_i[c] &  hit &  trk_killed[ch[c].id];
    assign bad[c]  = xif.co_result_valid_i[c] & !hit;
  end

  always_comb begin
    can_load = !out_valid || xif.result_ready_i;
    gnt_vld  = 1'b0;
    gnt      = '0;
    idx      = '0;
    for (int i = 0; i < NC; i++) begin
      idx = CW'((int'(ptr) + i) % NC);
      if (!gnt_vld && can_load && live[idx]) begin
        gnt_vld = 1'b1;
        gnt     = idx;
      end
    end
  end

  // Killed results free their entry without occupying the output stage.
  always_comb begin
    free   = '0;
    n_free = 0;
    rdy    = dead | bad;
    for (int c = 0; c < NC; c++)
      if (dead[c]) begin
        free[ch[c].id] = 1'b1;
        n_free         = n_free + 1;
      end
    if (gnt_vld) begin
      free[ch[gnt].id] = 1'b1;
      n_free           = n_free + 1;
      rdy[gnt]         = 1'b1;
    end
    dup     = xif.issue_alloc_i && trk_valid[xif.issue_id_i] && !free[xif.issue_id_i];
    cnt_nxt = int'(cnt_q) - n_free + ((xif.issue_alloc_i && !dup) ? 1 : 0);
    if (cnt_nxt > DEPTH) cnt_nxt = DEPTH;
    if (cnt_nxt < 0)     cnt_nxt = 0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trk_valid  <= '0;
      trk_killed <= '0;
      trk_owner  <= '0;
    end else begin
      // Priority: alloc over free over kill.
      for (int e = 0; e < DEPTH; e++) begin
        if (xif.issue_alloc_i && xif.issue_id_i == IW'(e)) begin
          trk_valid[e]  <= 1'b1;
          trk_killed[e] <= 1'b0;
          trk_owner[e]  <= xif.issue_coproc_i;
        end else if (free[e]) begin
          trk_valid[e]  <= 1'b0;
          trk_killed[e] <= 1'b0;
        end else if (xif.commit_valid_i && xif.commit_kill_i &&
                     xif.commit_id_i == IW'(e) && trk_valid[e]) begin
          trk_killed[e] <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_q     <= '0;
      ptr       <= '0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      if (can_load) begin
        out_valid <= gnt_vld;
        if (gnt_vld) out_q <= ch[gnt];
      end
      if (gnt_vld) ptr <= CW'((int'(gnt) + 1) % NC);
      err_q <= (|bad) || dup;
      cnt_q <= (IW+1)'(cnt_nxt);
    end
  end

  assign xif.co_result_ready_o = rst_n ? rdy : '0;
  assign xif.result_valid_o    = out_valid;
  assign xif.result_id_o       = out_q.id;
  assign xif.result_data_o     = out_q.data;
  assign xif.result_rd_o       = out_q.rd;
  assign xif.result_we_o       = out_q.we;
  assign xif.result_exc_o      = out_q.exc;
  assign xif.result_exccode_o  = out_q.exccode;
  assign xif.outstanding_cnt_o = cnt_q;
  assign xif.protocol_err_o    = err_q;
endmodule

// File: tb/tb_cv32e40x_xif_result_arbiter.sv
// Directed scenarios plus a randomized run against an ID-table reference model.
module tb_cv32e40x_xif_result_arbiter;
  localparam int N = 2;
  localparam int IW = 4;
  localparam int W = 32;
  localparam int D = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cv32e40x_xif_result_arbiter_if #(.X_NUM_COPROC(N), .X_ID_WIDTH(IW), .X_RFW_WIDTH(W)) xif();
  cv32e40x_xif_result_arbiter #(.X_NUM_COPROC(N), .X_ID_WIDTH(IW), .X_RFW_WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .xif(xif));

  int n_checks = 0;
  int n_pass = 0;

  // channel stimulus
  logic        c_vld [N];
  logic [3:0]  c_id  [N];
  logic [31:0] c_dat [N];
  logic [4:0]  c_rd  [N];
  logic        c_we  [N];
  logic        c_exc [N];
  logic [5:0]  c_ecd [N];

  // reference model: ID table + expected output stage
  bit          m_valid [D];
  bit          m_killed[D];
  int          m_owner [D];
  int          m_rr;
  bit          m_ov, m_err;
  logic [3:0]  m_id;
  logic [31:0] m_dat;
  logic [4:0]  m_rd;
  logic        m_we, m_exc;
  logic [5:0]  m_ecd;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic apply_ch();
    for (int c = 0; c < N; c++) begin
      xif.co_result_valid_i[c]         = c_vld[c];
      xif.co_result_id_i[c*4 +: 4]     = c_id[c];
      xif.co_result_data_i[c*32 +: 32] = c_dat[c];
      xif.co_result_rd_i[c*5 +: 5]     = c_rd[c];
      xif.co_result_we_i[c]            = c_we[c];
      xif.co_result_exc_i[c]           = c_exc[c];
      xif.co_result_exccode_i[c*6 +: 6] = c_ecd[c];
    end
  endtask

  task automatic idle();
    xif.issue_alloc_i = 0; xif.issue_id_i = '0; xif.issue_coproc_i = '0;
    xif.commit_valid_i = 0; xif.commit_id_i = '0; xif.commit_kill_i = 0;
    xif.result_ready_i = 1;
    for (int c = 0; c < N; c++) begin
      c_vld[c] = 0; c_id[c] = '0; c_dat[c] = '0; c_rd[c] = '0;
      c_we[c] = 0; c_exc[c] = 0; c_ecd[c] = '0;
    end
    apply_ch();
  endtask

  task automatic do_reset();
    idle();
    rst_n = 0;
    for (int e = 0; e < D; e++) begin m_valid[e] = 0; m_killed[e] = 0; m_owner[e] = 0; end
    m_rr = 0; m_ov = 0; m_err = 0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1;
  endtask

  task automatic alloc(input int id, input int ch);
    xif.issue_alloc_i = 1; xif.issue_id_i = 4'(id); xif.issue_coproc_i = 1'(ch);
    tick();
    xif.issue_alloc_i = 0;
  endtask

  task automatic set_ch(input int c, input logic v, input int id, input logic [31:0] d);
    c_vld[c] = v; c_id[c] = 4'(id); c_dat[c] = d; c_rd[c] = 5'(id + 1);
    apply_ch();
  endtask

  task automatic test_reset();
    idle();
    rst_n = 0;
    set_ch(0, 1, 0, 32'h1234);
    #3;
    n_checks++; if (xif.co_result_ready_o !== 2'b00) $display("FAIL rst_ready: got %b exp 00", xif.co_result_ready_o); else n_pass++;
    n_checks++; if (xif.result_valid_o !== 1'b0) $display("FAIL rst_valid: got %b exp 0", xif.result_valid_o); else n_pass++;
    n_checks++; if (xif.outstanding_cnt_o !== 5'd0) $display("FAIL rst_cnt: got %0d exp 0", xif.outstanding_cnt_o); else n_pass++;
    n_checks++; if (xif.protocol_err_o !== 1'b0) $display("FAIL rst_err: got %b exp 0", xif.protocol_err_o); else n_pass++;
    n_checks++; if (xif.result_data_o !== 32'd0) $display("FAIL rst_data: got %h exp 0", xif.result_data_o); else n_pass++;
    do_reset();
  endtask

  task automatic test_basic();
    do_reset();
    alloc(3, 0);
    n_checks++; if (xif.outstanding_cnt_o !== 5'd1) $display("FAIL basic_cnt1: got %0d exp 1", xif.outstanding_cnt_o); else n_pass++;
    set_ch(0, 1, 3, 32'hDEADBEEF);
    #1;
    n_checks++; if (xif.co_result_ready_o !== 2'b01) $display("FAIL basic_ready: got %b exp 01", xif.co_result_ready_o); else n_pass++;
    tick();
    set_ch(0, 0, 0, 0);
    n_checks++; if (xif.result_valid_o !== 1'b1) $display("FAIL basic_valid: got %b exp 1", xif.result_valid_o); else n_pass++;
    n_checks++; if (xif.result_id_o !== 4'd3) $display("FAIL basic_id: got %0d exp 3", xif.result_id_o); else n_pass++;
    n_checks++; if (xif.result_data_o !== 32'hDEADBEEF) $display("FAIL basic_data: got %h exp deadbeef", xif.result_data_o); else n_pass++;
    n_checks++; if (xif.outstanding_cnt_o !== 5'd0) $display("FAIL basic_cnt0: got %0d exp 0", xif.outstanding_cnt_o); else n_pass++;
    tick();
    n_checks++; if (xif.result_valid_o !== 1'b0) $display("FAIL basic_drain: got %b exp 0", xif.result_valid_o); else n_pass++;
  endtask

  task automatic test_round_robin();
    do_reset();
    alloc(1, 0); alloc(2, 1);
    set_ch(0, 1, 1, 32'hA1); set_ch(1, 1, 2, 32'hB2);
    #1;
    n_checks++; if (xif.co_result_ready_o !== 2'b01) $display("FAIL rr_first_ready: got %b exp 01", xif.co_result_ready_o); else n_pass++;
    tick();
    set_ch(0, 0, 0, 0);
    n_checks++; if (xif.result_id_o !== 4'd1) $display("FAIL rr_first_id: got %0d exp 1", xif.result_id_o); else n_pass++;
    #1;
    n_checks++; if (xif.co_result_ready_o !== 2'b10) $display("FAIL rr_second_ready: got %b exp 10", xif.co_result_ready_o); else n_pass++;
    tick();
    set_ch(1, 0, 0, 0);
    n_checks++; if (xif.result_id_o !== 4'd2) $display("FAIL rr_second_id: got %0d exp 2", xif.result_id_o); else n_pass++;
    // grant ch0 alone, then contend: ch1 must now win
    alloc(1, 0); alloc(2, 1); alloc(6, 0);
    set_ch(0, 1, 6, 32'hC6);
    tick();
    set_ch(0, 1, 1, 32'hA1); set_ch(1, 1, 2, 32'hB2);
    #1;
    n_checks++; if (xif.co_result_ready_o !== 2'b10) $display("FAIL rr_rotate_ready: got %b exp 10", xif.co_result_ready_o); else n_pass++;
    tick();
    set_ch(1, 0, 0, 0);
    n_checks++; if (xif.result_id_o !== 4'd2) $display("FAIL rr_rotate_id: got %0d exp 2", xif.result_id_o); else n_pass++;
    tick();
    set_ch(0, 0, 0, 0);
    n_checks++; if (xif.result_id_o !== 4'd1) $display("FAIL rr_rotate_id2: got %0d exp 1", xif.result_id_o); else n_pass++;
    tick();
  endtask

  task automatic test_backpressure();
    do_reset();
    alloc(1, 0); alloc(2, 0); alloc(3, 0);
    xif.result_ready_i = 0;
    set_ch(0, 1, 1, 32'h1111);
    tick();
    set_ch(0, 1, 2, 32'h2222);
    for (int k = 0; k < 5; k++) begin
      #1;
      n_checks++; if (xif.co_result_ready_o !== 2'b00) $display("FAIL bp_ready%0d: got %b exp 00", k, xif.co_result_ready_o); else n_pass++;
      tick();
      n_checks++; if ({xif.result_valid_o, xif.result_id_o, xif.result_data_o} !== {1'b1, 4'd1, 32'h1111})
        $display("FAIL bp_hold%0d: got %b/%0d/%h exp 1/1/1111", k, xif.result_valid_o, xif.result_id_o, xif.result_data_o); else n_pass++;
    end
    xif.result_ready_i = 1;
    #1;
    n_checks++; if (xif.co_result_ready_o !== 2'b01) $display("FAIL bp_release: got %b exp 01", xif.co_result_ready_o); else n_pass++;
    tick();
    set_ch(0, 1, 3, 32'h3333);
    n_checks++; if (xif.result_id_o !== 4'd2) $display("FAIL bp_tput1: got %0d exp 2", xif.result_id_o); else n_pass++;
    tick();
    set_ch(0, 0, 0, 0);
    n_checks++; if ({xif.result_valid_o, xif.result_id_o} !== {1'b1, 4'd3}) $display("FAIL bp_tput2: got %b/%0d exp 1/3", xif.result_valid_o, xif.result_id_o); else n_pass++;
    tick();
    n_checks++; if (xif.outstanding_cnt_o !== 5'd0) $display("FAIL bp_cnt: got %0d exp 0", xif.outstanding_cnt_o); else n_pass++;
  endtask

  task automatic test_kill();
    do_reset();
    alloc(5, 1);
    xif.commit_valid_i = 1; xif.commit_id_i = 4'd5; xif.commit_kill_i = 1;
    tick();
    xif.commit_valid_i = 0; xif.commit_kill_i = 0;
    set_ch(1, 1, 5, 32'h5555);
    #1;
    n_checks++; if (xif.co_result_ready_o !== 2'b10) $display("FAIL kill_ready: got %b exp 10", xif.co_result_ready_o); else n_pass++;
    tick();
    set_ch(1, 0, 0, 0);
    n_checks++; if (xif.result_valid_o !== 1'b0) $display("FAIL kill_valid: got %b exp 0", xif.result_valid_o); else n_pass++;
    n_checks++; if (xif.outstanding_cnt_o !== 5'd0) $display("FAIL kill_cnt: got %0d exp 0", xif.outstanding_cnt_o); else n_pass++;
    n_checks++; if (xif.protocol_err_o !== 1'b0) $display("FAIL kill_err: got %b exp 0", xif.protocol_err_o); else n_pass++;
  endtask

  task automatic test_protocol_err();
    do_reset();
    set_ch(0, 1, 7, 32'h7777);
    #1;
    n_checks++; if (xif.co_result_ready_o !== 2'b01) $display("FAIL bad_ready: got %b exp 01", xif.co_result_ready_o); else n_pass++;
    tick();
    set_ch(0, 0, 0, 0);
    n_checks++; if ({xif.protocol_err_o, xif.result_valid_o} !== 2'b10) $display("FAIL bad_err: got %b exp 10", {xif.protocol_err_o, xif.result_valid_o}); else n_pass++;
    tick();
    n_checks++; if (xif.protocol_err_o !== 1'b0) $display("FAIL bad_pulse: got %b exp 0", xif.protocol_err_o); else n_pass++;
    alloc(4, 0);
    n_checks++; if (xif.protocol_err_o !== 1'b0) $display("FAIL dup_first: got %b exp 0", xif.protocol_err_o); else n_pass++;
    alloc(4, 1);
    n_checks++; if (xif.protocol_err_o !== 1'b1) $display("FAIL dup_err: got %b exp 1", xif.protocol_err_o); else n_pass++;
    n_checks++; if (xif.outstanding_cnt_o !== 5'd1) $display("FAIL dup_cnt: got %0d exp 1", xif.outstanding_cnt_o); else n_pass++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    alloc(3, 0);
    xif.result_ready_i = 0;
    set_ch(0, 1, 3, 32'hCAFE);
    tick();
    set_ch(0, 0, 0, 0);
    n_checks++; if (xif.result_valid_o !== 1'b1) $display("FAIL mid_pre: got %b exp 1", xif.result_valid_o); else n_pass++;
    #2 rst_n = 0;
    #1;
    n_checks++; if ({xif.result_valid_o, xif.result_data_o, xif.outstanding_cnt_o} !== 38'd0)
      $display("FAIL mid_clear: got %b/%h/%0d exp 0/0/0", xif.result_valid_o, xif.result_data_o, xif.outstanding_cnt_o); else n_pass++;
    #3 rst_n = 1;
    xif.result_ready_i = 1;
    set_ch(0, 1, 3, 32'hCAFE);
    #1;
    n_checks++; if (xif.co_result_ready_o !== 2'b01) $display("FAIL mid_stale_ready: got %b exp 01", xif.co_result_ready_o); else n_pass++;
    tick();
    set_ch(0, 0, 0, 0);
    n_checks++; if ({xif.protocol_err_o, xif.result_valid_o} !== 2'b10) $display("FAIL mid_stale_err: got %b exp 10", {xif.protocol_err_o, xif.result_valid_o}); else n_pass++;
  endtask

  function automatic logic [3:0] pick_id(input int c);
    int s = $urandom_range(0, D-1);
    for (int k = 0; k < D; k++)
      if (m_valid[(s+k)%D] && m_owner[(s+k)%D] == c) return 4'((s+k)%D);
    return 4'(s);
  endfunction

  task automatic test_random();
    bit live[N], dead[N], bad[N], freed[D], dup, cl, bad_any;
    logic [N-1:0] exp_rdy;
    int g, cnt;
    do_reset();
    for (int cyc = 0; cyc < 300; cyc++) begin
      xif.issue_alloc_i  = ($urandom % 3) == 0;
      xif.issue_id_i     = 4'($urandom);
      xif.issue_coproc_i = 1'($urandom);
      xif.commit_valid_i = ($urandom % 4) == 0;
      xif.commit_kill_i  = 1'($urandom);
      xif.commit_id_i    = ($urandom % 2) ? pick_id(int'($urandom % N)) : 4'($urandom);
      xif.result_ready_i = ($urandom % 4) != 0;
      for (int c = 0; c < N; c++) begin
        c_vld[c] = 1'($urandom); c_id[c] = ($urandom % 5 != 0) ? pick_id(c) : 4'($urandom);
        c_dat[c] = $urandom; c_rd[c] = 5'($urandom); c_we[c] = 1'($urandom);
        c_exc[c] = 1'($urandom); c_ecd[c] = 6'($urandom);
      end
      apply_ch();
      #1;
      cl = !m_ov || xif.result_ready_i;
      g = -1; exp_rdy = '0; bad_any = 0;
      for (int e = 0; e < D; e++) freed[e] = 0;
      for (int c = 0; c < N; c++) begin
        bit own = c_vld[c] && m_valid[c_id[c]] && m_owner[c_id[c]] == c;
        live[c] = own && !m_killed[c_id[c]];
        dead[c] = own && m_killed[c_id[c]];
        bad[c]  = c_vld[c] && !own;
        if (dead[c]) freed[c_id[c]] = 1;
        exp_rdy[c] = dead[c] || bad[c];
        bad_any |= bad[c];
      end
      if (cl) for (int k = 0; k < N; k++) if (g < 0 && live[(m_rr+k)%N]) g = (m_rr+k)%N;
      if (g >= 0) begin exp_rdy[g] = 1; freed[c_id[g]] = 1; end
      n_checks++; if (xif.co_result_ready_o !== exp_rdy) $display("FAIL rnd_ready c%0d: got %b exp %b", cyc, xif.co_result_ready_o, exp_rdy); else n_pass++;
      dup = xif.issue_alloc_i && m_valid[xif.issue_id_i] && !freed[xif.issue_id_i];
      for (int e = 0; e < D; e++) if (freed[e]) begin m_valid[e] = 0; m_killed[e] = 0; end
      if (xif.commit_valid_i && xif.commit_kill_i && m_valid[xif.commit_id_i]) m_killed[xif.commit_id_i] = 1;
      if (xif.issue_alloc_i) begin
        m_valid[xif.issue_id_i] = 1; m_killed[xif.issue_id_i] = 0; m_owner[xif.issue_id_i] = int'(xif.issue_coproc_i);
      end
      if (cl) m_ov = (g >= 0);
      if (g >= 0) begin
        m_id = c_id[g]; m_dat = c_dat[g]; m_rd = c_rd[g]; m_we = c_we[g]; m_exc = c_exc[g]; m_ecd = c_ecd[g];
        m_rr = (g + 1) % N;
      end
      m_err = bad_any || dup;
      tick();
      cnt = 0;
      for (int e = 0; e < D; e++) cnt += int'(m_valid[e]);
      n_checks++; if (xif.result_valid_o !== m_ov) $display("FAIL rnd_valid c%0d: got %b exp %b", cyc, xif.result_valid_o, m_ov); else n_pass++;
      if (m_ov) begin
        n_checks++; if ({xif.result_id_o, xif.result_data_o, xif.result_rd_o, xif.result_we_o, xif.result_exc_o, xif.result_exccode_o}
                        !== {m_id, m_dat, m_rd, m_we, m_exc, m_ecd})
          $display("FAIL rnd_fields c%0d: got %0d/%h exp %0d/%h", cyc, xif.result_id_o, xif.result_data_o, m_id, m_dat); else n_pass++;
      end
      n_checks++; if (xif.outstanding_cnt_o !== 5'(cnt)) $display("FAIL rnd_cnt c%0d: got %0d exp %0d", cyc, xif.outstanding_cnt_o, cnt); else n_pass++;
      n_checks++; if (xif.protocol_err_o !== m_err) $display("FAIL rnd_err c%0d: got %b exp %b", cyc, xif.protocol_err_o, m_err); else n_pass++;
    end
  endtask

  initial begin
    idle();
    test_reset();
    test_basic();
    test_round_robin();
    test_backpressure();
    test_kill();
    test_protocol_err();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
